parity_frame_checker: RTL and testbench
=======================================

# parity_frame_checker

Downstream consumer of the even/odd 0s-and-1s parity-tracking FSM. It takes that FSM's one-hot state `y`, snapshots it at frame start, and after `FRAME_LEN` input bits computes the frame's own zeros/ones parity. It compares that result with an expected value and keeps saturating frame and error counts. It also flags any non-one-hot state code seen on `y`.

## Interface
- `FRAME_LEN`, 8: bits per frame. Must be ≥1.
- `CNT_W`, 8: width of the frame and error counters.
- `clk`  in  1  clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a frame. Honoured only in IDLE.
- `y`  in  4  upstream one-hot state. Codes: 1000 = even0/even1, 0100 = even0/odd1, 0010 = odd0/even1, 0001 = odd0/odd1.
- `exp_par`  in  2  expected frame parity, sampled with `start`. Bit [1] = zeros odd, bit [0] = ones odd.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a frame result is valid.
- `frame_par`  out  2  parity of the frame, same encoding as `exp_par`. Holds until the next `done`.
- `mismatch`  out  1  `frame_par` differs from the expected value, or the frame was aborted. Holds until the next `done`.
- `illegal`  out  1  sticky. Set when a non-one-hot `y` is sampled in a cycle where `y` is used (start edge or RUN). Cleared only by `reset`.
- `frame_cnt`  out  CNT_W  completed frames, counting aborted frames. Saturates at all-ones.
- `err_cnt`  out  CNT_W  frames with `mismatch` = 1. Saturates at all-ones.

## Operation
- Decoding `y`:
  - ones-parity `po` = `y[2] | y[0]`.
  - zeros-parity `pz` = `y[1] | y[0]`.
  - One-hot check: exactly one bit set.
- States: IDLE and RUN.
- Start edge, in IDLE with `start` = 1 and `y` legal:
  - Store `{pz, po}` to snapshot `snap`.
  - Store `exp_par`.
  - Set bit counter to 0 and go to RUN.
- Start edge with `y` illegal:
  - Set `illegal`.
  - Stay in IDLE.
  - Issue an abort result: `done` next cycle, `frame_par` = 00, `mismatch` = 1.
- RUN edges:
  - If `y` is illegal: set `illegal`, issue an abort result, go to IDLE.
  - Otherwise, if counter = `FRAME_LEN`-1: `frame_par` ← `{pz, po}` XOR `snap`, `mismatch` ← (`frame_par` ≠ stored expected value), go to IDLE.
  - Otherwise: increment the counter.
- On every result, normal or abort:
  - `done` = 1 for exactly one cycle.
  - `frame_cnt` +1, saturating.
  - `err_cnt` +1 if `mismatch`, saturating.
- `start` while `busy` is ignored. No queueing.
- Reset, including mid-frame:
  - Go to IDLE.
  - All outputs 0: `busy`, `done`, `frame_par`, `mismatch`, `illegal`, `frame_cnt`, `err_cnt`.
  - Clear the snapshot and the counter.
  - No `done` is issued for a frame interrupted by reset.

## Timing
- Let `start` be accepted at the end of cycle t.
- The frame covers the upstream bits clocked at the edges ending cycles t .. t+FRAME_LEN-1.
- `busy` is high in cycles t+1 .. t+FRAME_LEN.
- `done` is high in cycle t+FRAME_LEN+1, with `frame_par` and `mismatch` valid. Latency is `FRAME_LEN`+1 cycles from the start cycle.
- `frame_cnt` and `err_cnt` update in the same cycle that `done` is high.
- Abort detected in RUN cycle k: `done` is high in cycle k+1 and `busy` is low in cycle k+1.
- `start` may be asserted in the cycle `done` is high, since that cycle is IDLE. The minimum start-to-start period is `FRAME_LEN`+1 cycles.
- Counter saturation: at all-ones, further increments leave the value unchanged.

## Test plan
All scenarios use `FRAME_LEN` = 8 and `CNT_W` = 8.
- **Reset.** Hold `reset` for 2 cycles with random `y` and `start`.
  - All outputs are 0 and `busy` stays 0.
- **Null frame.** `y` = 1000 throughout, `start` with `exp_par` = 00 at cycle 5.
  - `busy` is high in cycles 6–13.
  - `done` pulses in cycle 14 with `frame_par` = 00, `mismatch` = 0.
  - `frame_cnt` = 1, `err_cnt` = 0.
- **Parity change.** `y` = 0100 at start, `exp_par` = 10, `y` = 0001 in the last RUN cycle.
  - `frame_par` = 10, `mismatch` = 0.
  - Repeat with `exp_par` = 01: `mismatch` = 1 and `err_cnt` increments.
- **Abort.** Drive `y` = 0110 in the 3rd RUN cycle.
  - `illegal` = 1 and `done` pulses the next cycle with `frame_par` = 00, `mismatch` = 1.
  - `busy` falls in the same cycle.
  - `illegal` remains 1 through later clean frames until `reset`.
- **Reset mid-frame and busy start.**
  - Assert `reset` in the 4th RUN cycle: no `done` follows and both counters are 0.
  - `start` pulses during `busy` are ignored: exactly one `done` per accepted start.
- **Saturation.** Run 260 mismatching frames back-to-back, each `start` issued in the `done` cycle.
  - `frame_cnt` and `err_cnt` stop at 255.

Source files
------------

// File: rtl/parity_frame_checker_if.sv
// Bus between the parity frame checker and its driver: frame request
// inputs plus the result, status and counter outputs.
interface parity_frame_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [3:0]       y;
  logic [1:0]       exp_par;
  logic             busy;
  logic             done;
  logic [1:0]       frame_par;
  logic             mismatch;
  logic             illegal;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output start, y, exp_par,
    input  busy, done, frame_par, mismatch, illegal, frame_cnt, err_cnt
  );

  modport slave (
    input  start, y, exp_par,
    output busy, done, frame_par, mismatch, illegal, frame_cnt, err_cnt
  );
endinterface

// File: rtl/parity_frame_checker.sv
// Parity frame checker: snapshots the upstream one-hot zeros/ones parity
// state at frame start, and after FRAME_LEN bits derives the frame's own
// parity by XOR against the snapshot. Compares with the expected parity,
// keeps saturating frame/error counts and a sticky illegal-code flag.
module parity_frame_checker #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  parity_frame_checker_if.slave bus
);

  localparam int unsigned BC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_LEN - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_snap;
  logic [1:0]       r_exp;
  logic [BC_W-1:0]  r_bit_cnt;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       r_frame_par;
  logic             r_mismatch;
  logic             r_illegal;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_po;
  logic             w_pz;
  logic [1:0]       w_cur_par;
  logic             w_onehot;
  logic [1:0]       w_frame_xor;
  logic             w_last_bit;
  logic             w_post;
  logic [1:0]       w_post_par;
  logic             w_post_mm;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Decode the upstream state into {zeros odd, ones odd} and check one-hot.
  always_comb begin
    w_po        = bus.y[2] | bus.y[0];
    w_pz        = bus.y[1] | bus.y[0];
    w_cur_par   = {w_pz, w_po};
    w_onehot    = (bus.y == 4'b1000) || (bus.y == 4'b0100) ||
                  (bus.y == 4'b0010) || (bus.y == 4'b0001);
    w_frame_xor = w_cur_par ^ r_snap;
    w_last_bit  = (r_bit_cnt == LAST_BIT);
  end

  // Decide whether this edge posts a result (normal end of frame or abort)
  // and what that result is; the FSM below registers it.
  always_comb begin
    w_post     = 1'b0;
    w_post_par = '0;
    w_post_mm  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !w_onehot) begin
          w_post    = 1'b1;
          w_post_mm = 1'b1;
        end
      end
      S_RUN: begin
        if (!w_onehot) begin
          w_post    = 1'b1;
          w_post_mm = 1'b1;
        end else if (w_last_bit) begin
          w_post     = 1'b1;
          w_post_par = w_frame_xor;
          w_post_mm  = (w_frame_xor != r_exp);
        end
      end
      default: ;
    endcase
  end

  // Frame FSM with registered status, result and counter outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_snap      <= '0;
      r_exp       <= '0;
      r_bit_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_par <= '0;
      r_mismatch  <= 1'b0;
      r_illegal   <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_done <= w_post;
      if (w_post) begin
        r_frame_par <= w_post_par;
        r_mismatch  <= w_post_mm;
        r_frame_cnt <= sat_inc(r_frame_cnt);
        if (w_post_mm) begin
          r_err_cnt <= sat_inc(r_err_cnt);
        end
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_onehot) begin
              r_snap    <= w_cur_par;
              r_exp     <= bus.exp_par;
              r_bit_cnt <= '0;
              r_busy    <= 1'b1;
              r_state   <= S_RUN;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!w_onehot) begin
            r_illegal <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_last_bit) begin
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.frame_par = r_frame_par;
  assign bus.mismatch  = r_mismatch;
  assign bus.illegal   = r_illegal;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: drives frames from tasks, pushes the
// expected result of each frame into a scoreboard when it is started and
// compares it when done pulses.
module tb_parity_frame_checker;

  localparam int unsigned FL = 8;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [1:0] fp;
    logic       mm;
    logic       il;
    logic [7:0] fc;
    logic [7:0] ec;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  parity_frame_checker_if #(.CNT_W(CW)) bus ();

  parity_frame_checker #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int unsigned n_checks   = 0;
  int unsigned n_errors   = 0;
  int unsigned n_done     = 0;
  int unsigned n_expected = 0;
  logic [7:0]  m_fc = '0;
  logic [7:0]  m_ec = '0;
  logic        m_il = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] par_of(input logic [3:0] yv);
    return {yv[1] | yv[0], yv[2] | yv[0]};
  endfunction

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic push_result(input logic [1:0] fp, input logic mm);
    exp_t e;
    m_fc = sat(m_fc);
    if (mm) m_ec = sat(m_ec);
    e.fp = fp; e.mm = mm; e.il = m_il; e.fc = m_fc; e.ec = m_ec;
    sb.push_back(e);
    n_expected++;
  endtask

  // Result monitor: every done pulse must match the oldest expected frame.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.done === 1'b1) begin
      n_done++;
      check("sb_nonempty_on_done", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("frame_par", bus.frame_par, e.fp);
        check("mismatch",  bus.mismatch,  e.mm);
        check("illegal",   bus.illegal,   e.il);
        check("frame_cnt", bus.frame_cnt, e.fc);
        check("err_cnt",   bus.err_cnt,   e.ec);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_done"},      bus.done,      0);
    check({tag, "_frame_par"}, bus.frame_par, 0);
    check({tag, "_mismatch"},  bus.mismatch,  0);
    check({tag, "_illegal"},   bus.illegal,   0);
    check({tag, "_frame_cnt"}, bus.frame_cnt, 0);
    check({tag, "_err_cnt"},   bus.err_cnt,   0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.start   = 1'($urandom_range(0, 1));
      bus.y       = 4'($urandom);
      bus.exp_par = 2'($urandom);
      @(negedge clk);
      check_all_zero("reset");
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.y     = 4'b1000;
    m_fc = '0; m_ec = '0; m_il = 1'b0;
    sb.delete();
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy", bus.busy, 0);
    end
  endtask

  // Start a frame in the current cycle; returns positioned in the done cycle.
  task automatic run_frame(input logic [3:0] y0, input logic [3:0] ylast,
                           input logic [1:0] ep, input int abort_at,
                           input logic noise_start);
    logic [1:0] fp;
    bus.start   = 1'b1;
    bus.y       = y0;
    bus.exp_par = ep;
    if (abort_at > 0) begin
      m_il = 1'b1;
      push_result(2'b00, 1'b1);
    end else begin
      fp = par_of(ylast) ^ par_of(y0);
      push_result(fp, fp != ep);
    end
    @(negedge clk);
    for (int k = 1; k <= int'(FL); k++) begin
      check("busy_run", bus.busy, 1);
      check("done_low_run", bus.done, 0);
      bus.start   = noise_start ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.exp_par = 2'($urandom);
      if (k == abort_at)      bus.y = 4'b0110;
      else if (k == int'(FL)) bus.y = ylast;
      else                    bus.y = y0;
      @(negedge clk);
      if (k == abort_at) break;
    end
    check("done_pulse", bus.done, 1);
    check("busy_after", bus.busy, 0);
    bus.start = 1'b0;
    bus.y     = 4'b1000;
  endtask

  task automatic start_illegal();
    bus.start = 1'b1;
    bus.y     = 4'b1001;
    m_il = 1'b1;
    push_result(2'b00, 1'b1);
    @(negedge clk);
    check("illegal_start_done", bus.done, 1);
    check("illegal_start_busy", bus.busy, 0);
    bus.start = 1'b0;
    bus.y     = 4'b1000;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int unsigned done_before;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.y       = 4'b1000;
    bus.exp_par = 2'b00;
    @(negedge clk);
    do_reset();
    idle(3);

    // Null frame, then parity change matching and mismatching.
    run_frame(4'b1000, 4'b1000, 2'b00, 0, 1'b0);
    idle(2);
    run_frame(4'b0100, 4'b0001, 2'b10, 0, 1'b0);
    run_frame(4'b0100, 4'b0001, 2'b01, 0, 1'b0);
    run_frame(4'b0010, 4'b1000, 2'b10, 0, 1'b0);
    idle(1);

    // Abort in 3rd RUN cycle; illegal must stick through clean frames.
    run_frame(4'b1000, 4'b1000, 2'b00, 3, 1'b0);
    idle(1);
    check("illegal_sticky", bus.illegal, 1);
    run_frame(4'b0001, 4'b0100, 2'b11, 0, 1'b0);
    run_frame(4'b1000, 4'b0010, 2'b01, 0, 1'b0);
    start_illegal();
    idle(2);

    // Start pulses during busy must be ignored.
    run_frame(4'b0100, 4'b0010, 2'b11, 0, 1'b1);
    run_frame(4'b0001, 4'b0001, 2'b00, 0, 1'b1);
    idle(3);

    // Reset in the 4th RUN cycle: no done, counters cleared.
    bus.start = 1'b1;
    bus.y     = 4'b1000;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k < 4; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_fc = '0; m_ec = '0; m_il = 1'b0;
    check_all_zero("midreset");
    done_before = n_done;
    idle(12);
    check("midreset_no_done", n_done - done_before, 0);
    check("midreset_frame_cnt", bus.frame_cnt, 0);
    check("midreset_err_cnt", bus.err_cnt, 0);

    // Saturation: back-to-back mismatching frames.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      run_frame(4'b1000, 4'b1000, 2'b01, 0, 1'b0);
    end
    idle(2);
    check("sat_frame_cnt", bus.frame_cnt, 8'hFF);
    check("sat_err_cnt", bus.err_cnt, 8'hFF);

    check("sb_empty", sb.size(), 0);
    check("done_count", n_done, n_expected);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
